// File: rtl/antirrebote_pkg.sv
// Shared constants, hold-sequencer state type and counter-width helpers for the debouncer.
// Defaults assume a 50 MHz clk.
package antirrebote_pkg;

  localparam int DEF_COUNT  = 100;
  localparam int DEF_LONG   = 50_000_000;
  localparam int DEF_REPEAT = 10_000_000;

  typedef enum logic [1:0] {
    H_IDLE,
    H_PRESS,
    H_REPEAT
  } hold_state_t;

  function automatic int deb_width(input int count);
    return (count < 1) ? 1 : $clog2(count + 1);
  endfunction

  function automatic int hold_width(input int long_c, input int rep_c);
    int m;
    m = (long_c > rep_c) ? long_c : rep_c;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/antirrebote_if.sv
// Button bundle: raw levels in, debounced levels and event pulses out.
// Master drives btn (board / bench side); slave is the debouncer.
interface antirrebote_if #(
  parameter int N = 4
);
  logic [N-1:0] btn;
  logic [N-1:0] clean;
  logic [N-1:0] rise;
  logic [N-1:0] fall;
  logic [N-1:0] long_press;
  logic [N-1:0] rpt;
  logic         any_evt;

  modport master (
    output btn,
    input  clean, rise, fall, long_press, rpt, any_evt
  );

  modport slave (
    input  btn,
    output clean, rise, fall, long_press, rpt, any_evt
  );
endinterface

// File: rtl/antirrebote_canal.sv
// One debounce channel: 2-flop sync, stability counter, edge pulses, long-press/repeat sequencer.
// clean moves COUNT+2 edges after a stable new level; every output is a flop; no backpressure.
module antirrebote_canal
  import antirrebote_pkg::*;
#(
  parameter int COUNT  = DEF_COUNT,
  parameter int LONG   = DEF_LONG,
  parameter int REPEAT = DEF_REPEAT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic clean,
  output logic rise,
  output logic fall,
  output logic long_press,
  output logic rpt,
  output logic rise_nxt
);

  localparam int DEB_W  = deb_width(COUNT);
  localparam int HOLD_W = hold_width(LONG, REPEAT);

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(COUNT - 1);
  localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG - 1);
  localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'((REPEAT > 0) ? REPEAT - 1 : 0);

  logic              sync_q1, sync_q2;
  logic [DEB_W-1:0]  deb_cnt, deb_cnt_d;
  logic              clean_d;
  hold_state_t       st, st_d;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_d;
  logic              long_d, rpt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= btn;
      sync_q2 <= sync_q1;
    end
  end

  // Counter only runs while the synchronised level disagrees with clean; any agreement restarts it.
  always_comb begin
    deb_cnt_d = '0;
    clean_d   = clean;
    if (sync_q2 != clean) begin
      if (deb_cnt == DEB_LAST) begin
        clean_d = sync_q2;
      end else begin
        deb_cnt_d = deb_cnt + 1'b1;
      end
    end
  end

  // Decisions use clean_d so a release cancels any pulse due in the fall cycle itself.
  always_comb begin
    st_d       = st;
    hold_cnt_d = hold_cnt;
    long_d     = 1'b0;
    rpt_d      = 1'b0;
    if (!clean_d) begin
      st_d       = H_IDLE;
      hold_cnt_d = '0;
    end else begin
      case (st)
        H_IDLE: begin
          st_d       = H_PRESS;
          hold_cnt_d = '0;
        end
        H_PRESS: begin
          if (hold_cnt == LONG_LAST) begin
            long_d     = 1'b1;
            st_d       = H_REPEAT;
            hold_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_cnt + 1'b1;
          end
        end
        H_REPEAT: begin
          if (REPEAT > 0) begin
            if (hold_cnt == REP_LAST) begin
              rpt_d      = 1'b1;
              hold_cnt_d = '0;
            end else begin
              hold_cnt_d = hold_cnt + 1'b1;
            end
          end
        end
        default: begin
          st_d       = H_IDLE;
          hold_cnt_d = '0;
        end
      endcase
    end
  end

  assign rise_nxt = clean_d & ~clean;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_cnt    <= '0;
      clean      <= 1'b0;
      rise       <= 1'b0;
      fall       <= 1'b0;
      st         <= H_IDLE;
      hold_cnt   <= '0;
      long_press <= 1'b0;
      rpt        <= 1'b0;
    end else begin
      deb_cnt    <= deb_cnt_d;
      clean      <= clean_d;
      rise       <= clean_d & ~clean;
      fall       <= ~clean_d & clean;
      st         <= st_d;
      hold_cnt   <= hold_cnt_d;
      long_press <= long_d;
      rpt        <= rpt_d;
    end
  end

endmodule

// File: rtl/antirrebote_n.sv
// N-channel button debouncer with press/release/long-press/auto-repeat pulses.
// clean and pulses lag a stable input by COUNT+2 edges; all outputs registered; no backpressure.
module antirrebote_n
  import antirrebote_pkg::*;
#(
  parameter int N          = 4,
  parameter int COUNT      = DEF_COUNT,
  parameter int LONG       = DEF_LONG,
  parameter int REPEAT     = DEF_REPEAT,
  parameter int ACTIVE_LOW = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  antirrebote_if.slave bus
);

  logic [N-1:0] btn_norm;
  logic [N-1:0] clean_v, rise_v, fall_v, long_v, rpt_v, rise_nxt_v;

  assign btn_norm = (ACTIVE_LOW != 0) ? ~bus.btn : bus.btn;

  for (genvar i = 0; i < N; i++) begin : gen_ch
    antirrebote_canal #(
      .COUNT (COUNT),
      .LONG  (LONG),
      .REPEAT(REPEAT)
    ) u_canal (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn       (btn_norm[i]),
      .clean     (clean_v[i]),
      .rise      (rise_v[i]),
      .fall      (fall_v[i]),
      .long_press(long_v[i]),
      .rpt       (rpt_v[i]),
      .rise_nxt  (rise_nxt_v[i])
    );
  end

  // Registered from the channels' next-rise terms so it lines up with rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.any_evt <= 1'b0;
    end else begin
      bus.any_evt <= |rise_nxt_v;
    end
  end

  assign bus.clean      = clean_v;
  assign bus.rise       = rise_v;
  assign bus.fall       = fall_v;
  assign bus.long_press = long_v;
  assign bus.rpt        = rpt_v;

endmodule

// File: doc/antirrebote_n.md
ANTIRREBOTE_N -- requirements
Module: antirrebote_n

Interface
REQ-001 Parameter N, default 4, number of independent button channels (1..32).
REQ-002 Parameter COUNT, default 100, consecutive stable cycles required to accept a new level (>=2).
REQ-003 Parameter LONG, default 50_000_000, cycles clean must stay pressed before long_press fires (>COUNT).
REQ-004 Parameter REPEAT, default 10_000_000, auto-repeat period after long press; 0 disables repeat.
REQ-005 Parameter ACTIVE_LOW, default 0; 1 inverts every btn bit before synchronisation.
REQ-006 clk  input  1  single system clock, all logic on rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 btn  input  N  raw, asynchronous button levels.
REQ-009 clean  output  N  debounced level per channel, 1 = pressed.
REQ-010 rise  output  N  one-cycle press pulse per channel.
REQ-011 fall  output  N  one-cycle release pulse per channel.
REQ-012 long_press  output  N  one-cycle pulse when hold reaches LONG.
REQ-013 rpt  output  N  one-cycle auto-repeat pulse during a long hold.
REQ-014 any_evt  output  1  OR of all rise bits, same cycle.

Function
REQ-015 Each channel SHALL pass its (polarity-normalised) input through a two-flop synchroniser; only the second flop feeds the debounce logic.
REQ-016 Debounce counter width SHALL be $clog2(COUNT+1); hold counter width $clog2(max(LONG,REPEAT)+1); no counter SHALL wrap.
REQ-017 When synchronised level equals clean, the debounce counter SHALL clear to 0.
REQ-018 When they differ, the counter SHALL increment; on the COUNT-th consecutive differing edge clean SHALL take the synchronised level and the counter clear.
REQ-019 Latency: clean changes on the (COUNT+2)-th rising edge counting the first edge that samples a stable new btn level.
REQ-020 Any input pulse or glitch shorter than COUNT synchronised cycles SHALL leave clean unchanged and reset the count.
REQ-021 rise[i] SHALL be high exactly in the first cycle clean[i] reads 1; fall[i] exactly in the first cycle clean[i] reads 0.
REQ-022 Hold counter SHALL clear while clean[i]=0 and count cycles while clean[i]=1.
REQ-023 long_press[i] SHALL pulse one cycle when the hold count reaches LONG cycles after rise[i]; only once per press.
REQ-024 If REPEAT>0, rpt[i] SHALL pulse every REPEAT cycles after long_press[i] while clean[i] stays 1; first rpt REPEAT cycles after long_press.
REQ-025 Release (fall) SHALL immediately stop long/repeat sequencing; no pulse fires in or after the fall cycle.
REQ-026 Channels SHALL be fully independent; simultaneous events on several channels each produce their own pulses in the same cycle.
REQ-027 All outputs SHALL be registered; no combinational path from btn to any output.

Reset
REQ-028 rst_n low SHALL asynchronously clear synchronisers, counters, clean, rise, fall, long_press, rpt, any_evt to 0.
REQ-029 Reset asserted mid-debounce or mid-hold SHALL abort it; after release a held button re-debounces from zero and produces a fresh rise.
REQ-030 Deassertion SHALL be treated as synchronous to clk by the integrator; block requires no extra cycles after release.

Structure
REQ-031 Shared package antirrebote_pkg SHALL hold counter-width helper functions and default COUNT/LONG/REPEAT constants for 50 MHz.
REQ-032 Per-channel logic SHALL be one sub-module antirrebote_canal, instantiated N times by a generate loop; top adds polarity inversion and any_evt.

Verification
REQ-033 N=3, COUNT=4: btn[0] 0->1 stable -> clean[0]=1 and rise[0] pulse on the 6th edge; other channels stay 0.
REQ-034 COUNT=4: btn[1] high 3 cycles then low -> clean[1], rise[1] never assert; counter back to 0.
REQ-035 COUNT=4, LONG=10, REPEAT=5: hold btn[2] 40 cycles -> one long_press 10 cycles after rise, rpt at +15,+20,+25,+30,+35 from rise.
REQ-036 LONG=10: release at 8 cycles after rise -> fall pulse, no long_press, no rpt.
REQ-037 btn=3'b111 in one cycle -> rise=3'b111 and any_evt=1 in the same single cycle.
REQ-038 ACTIVE_LOW=1, btn held 0, rst_n pulsed low mid-hold -> all outputs 0 immediately; after release rise re-fires COUNT+2 edges later.
